data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a fixed-latency request/response handshake.
// Captures a load or store, waits LATENCY cycles, then answers with a one-cycle done pulse.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  fsm_state
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  count;
    logic [31:0] mem [DEPTH_WORDS];

    logic        cap_read;
    logic        cap_write;
    logic [2:0]  cap_funct3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic             req;
    logic             idle_capture;
    logic             enter_resp;
    logic             op_read;
    logic             op_write;
    logic [2:0]       op_funct3;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;
    logic [IDX_W-1:0] op_idx;
    logic             fault;
    logic [31:0]      old_word;
    logic [31:0]      new_word;
    logic [31:0]      load_val;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;

    // With LATENCY=0 the access completes on its capture edge, so the operands
    // come straight from the inputs while IDLE and from the capture registers otherwise.
    always_comb begin
        req          = MemRead | MemWrite;
        idle_capture = (state == IDLE) && req;
        enter_resp   = ((state == WAIT) && (count == 4'd0)) || (idle_capture && (LATENCY == 0));

        op_read   = (state == IDLE) ? MemRead  : cap_read;
        op_write  = (state == IDLE) ? MemWrite : cap_write;
        op_funct3 = (state == IDLE) ? funct3   : cap_funct3;
        op_addr   = (state == IDLE) ? addr     : cap_addr;
        op_wdata  = (state == IDLE) ? wdata    : cap_wdata;
        op_idx    = op_addr[IDX_W+1:2];
        old_word  = mem[op_idx];

        case (op_funct3)
            3'b000:  fault = 1'b0;
            3'b001:  fault = op_addr[0];
            3'b010:  fault = (op_addr[1:0] != 2'b00);
            3'b100:  fault = op_write;
            3'b101:  fault = op_write | op_addr[0];
            default: fault = 1'b1;
        endcase
        if ((op_read && op_write) || (op_addr[31:2] >= 30'(DEPTH_WORDS))) begin
            fault = 1'b1;
        end

        lane_byte = old_word[{op_addr[1:0], 3'b000} +: 8];
        lane_half = op_addr[1] ? old_word[31:16] : old_word[15:0];
        case (op_funct3)
            3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_val = {24'd0, lane_byte};
            3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_val = {16'd0, lane_half};
            default: load_val = old_word;
        endcase

        new_word = old_word;
        case (op_funct3[1:0])
            2'b00: new_word[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
            2'b01: begin
                if (op_addr[1]) new_word[31:16] = op_wdata[15:0];
                else            new_word[15:0]  = op_wdata[15:0];
            end
            default: new_word = op_wdata;
        endcase

        stall     = !reset && (idle_capture || (state == WAIT));
        fsm_state = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'd0;
        end else begin
            done <= enter_resp;
            err  <= enter_resp && fault;
            if (enter_resp) begin
                rdata <= (fault || !op_read) ? 32'd0 : load_val;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            count <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (count == 4'd0) state <= RESP;
                    else               count <= count - 4'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (idle_capture) begin
            cap_read   <= MemRead;
            cap_write  <= MemWrite;
            cap_funct3 <= funct3;
            cap_addr   <= addr;
            cap_wdata  <= wdata;
        end
    end

    // Storage is deliberately outside the reset domain; a reset edge only blocks the commit.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && op_write && !fault) begin
            mem[op_idx] <= new_word;
        end
    end
endmodule
